// File: rtl/edge_filter_pkg.sv
// Shared types for the streaming 3x3 edge filter: controller states and kernel mode encoding.
package edge_filter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    MODE_SUM  = 2'd0,
    MODE_GX   = 2'd1,
    MODE_GY   = 2'd2,
    MODE_BLUR = 2'd3
  } mode_e;

endpackage

// File: rtl/stream_edge_filter_kernel3x3.sv
// Combinational 3x3 kernel: Sobel magnitude (saturated) or 1-2-1 Gaussian blur.
// Window is row-major, pixel 0 = top-left, pixel 8 = bottom-right.
module kernel3x3 import edge_filter_pkg::*; #(
  parameter int DATA_W = 8
) (
  input  logic [9*DATA_W-1:0] win_i,
  input  logic [1:0]          mode_i,
  output logic [DATA_W-1:0]   pix_o
);

  localparam int SW = DATA_W + 4;

  logic signed [SW-1:0] p [9];
  logic signed [SW-1:0] gx, gy;
  logic        [SW-1:0] ax, ay, mag, bsum;

  for (genvar i = 0; i < 9; i++) begin : g_pix
    assign p[i] = $signed({4'b0000, win_i[i*DATA_W +: DATA_W]});
  end

  assign gx = (p[2] + p[5] + p[5] + p[8]) - (p[0] + p[3] + p[3] + p[6]);
  assign gy = (p[6] + p[7] + p[7] + p[8]) - (p[0] + p[1] + p[1] + p[2]);
  assign ax = gx[SW-1] ? $unsigned(-gx) : $unsigned(gx);
  assign ay = gy[SW-1] ? $unsigned(-gy) : $unsigned(gy);

  // Weights sum to 16, so the full sum fits SW bits before the shift.
  assign bsum = $unsigned(p[0] + (p[1] <<< 1) + p[2] + (p[3] <<< 1) + (p[4] <<< 2)
                        + (p[5] <<< 1) + p[6] + (p[7] <<< 1) + p[8]);

  always_comb begin
    mag = ax + ay;
    case (mode_e'(mode_i))
      MODE_GX: mag = ax;
      MODE_GY: mag = ay;
      default: ;
    endcase
    if (mode_e'(mode_i) == MODE_BLUR) pix_o = DATA_W'(bsum >> 4);
    else if (|mag[SW-1:DATA_W])        pix_o = '1;
    else                               pix_o = mag[DATA_W-1:0];
  end

endmodule

// File: rtl/stream_edge_filter.sv
// Raster-stream 3x3 filter with two line buffers; output (x,y) emerges IMG_W+1 pixels after input (x,y).
// Output register holds until m_ready; input stalls while a held output is pending.
module stream_edge_filter import edge_filter_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_sof,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_sof,
  output logic              m_eol,
  output logic              busy
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H + 2);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
  localparam logic [YW-1:0] Y_DONE = YW'(IMG_H);

  state_e state_q, state_d;
  mode_e  mode_q, mode_d;
  logic [XW-1:0] ix_q, ix_d, ox_q, ox_d;
  logic [YW-1:0] iy_q, iy_d, oy_q, oy_d;
  logic m_valid_q, m_valid_d, m_sof_q, m_sof_d, m_eol_q, m_eol_d;
  logic [DATA_W-1:0] m_data_q, m_data_d, kpix, pin;
  logic [DATA_W-1:0] lb0 [IMG_W];
  logic [DATA_W-1:0] lb1 [IMG_W];
  logic [DATA_W-1:0] col_l_q [3];
  logic [DATA_W-1:0] col_m_q [3];
  logic [DATA_W-1:0] col_n [3];
  logic [DATA_W-1:0] cols [3][3];
  logic [9*DATA_W-1:0] win;
  logic [XW-1:0] addr;
  logic acc, take_sof, in_step, flush_step, step, emit, fill_done, last_in;

  // ---------------- FSM: state register / next state / outputs
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (take_sof) state_d = ST_FILL;
    else begin
      case (state_q)
        ST_FILL:  if (in_step && fill_done) state_d = ST_RUN;
        ST_RUN:   if (in_step && last_in) state_d = ST_FLUSH;
        ST_FLUSH: if (oy_q == Y_DONE && (m_ready || !m_valid_q)) state_d = ST_IDLE;
        default:  ;
      endcase
    end
  end

  always_comb begin
    s_ready    = 1'b0;
    flush_step = 1'b0;
    case (state_q)
      ST_IDLE, ST_FILL: s_ready = 1'b1;
      ST_RUN:           s_ready = m_ready | ~m_valid_q;
      ST_FLUSH:         flush_step = (m_ready | ~m_valid_q) & (oy_q != Y_DONE);
      default:          ;
    endcase
    if (rst) begin
      s_ready    = 1'b0;
      flush_step = 1'b0;
    end
    busy = (state_q != ST_IDLE);
  end

  assign acc       = s_valid & s_ready;
  assign take_sof  = acc & s_sof;
  assign in_step   = acc & ~s_sof & (state_q != ST_IDLE);
  assign step      = take_sof | in_step | flush_step;
  assign fill_done = (state_q == ST_FILL) && (ix_q == XW'(1)) && (iy_q == YW'(1));
  assign last_in   = (state_q == ST_RUN) && (ix_q == X_LAST) && (iy_q == Y_LAST);
  assign emit      = (in_step & ((state_q == ST_RUN) | fill_done)) | flush_step;

  // ---------------- window: two stored columns plus the column arriving this step
  assign pin      = flush_step ? '0 : s_data;
  assign addr     = take_sof ? '0 : ix_q;
  assign col_n[0] = lb1[addr];
  assign col_n[1] = lb0[addr];
  assign col_n[2] = pin;
  assign cols[0]  = col_l_q;
  assign cols[1]  = col_m_q;
  assign cols[2]  = col_n;

  // Borders are zeroed from the output position, so stale line-buffer data never leaks in.
  always_comb begin
    win = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (!((r == 0 && oy_q == '0) || (r == 2 && oy_q == Y_LAST) ||
              (c == 0 && ox_q == '0) || (c == 2 && ox_q == X_LAST)))
          win[(3*r+c)*DATA_W +: DATA_W] = cols[c][r];
      end
    end
  end

  kernel3x3 #(.DATA_W(DATA_W)) u_kernel (
    .win_i  (win),
    .mode_i (mode_q),
    .pix_o  (kpix)
  );

  always_ff @(posedge clk) begin
    if (step) begin
      lb0[addr] <= pin;
      lb1[addr] <= lb0[addr];
      col_l_q   <= col_m_q;
      col_m_q   <= col_n;
    end
  end

  // ---------------- counters and output register
  always_comb begin
    ix_d = ix_q;  iy_d = iy_q;  ox_d = ox_q;  oy_d = oy_q;  mode_d = mode_q;
    m_valid_d = m_valid_q & ~m_ready;
    m_data_d  = m_data_q;  m_sof_d = m_sof_q;  m_eol_d = m_eol_q;
    if (take_sof) begin
      ix_d = XW'(1);  iy_d = '0;  ox_d = '0;  oy_d = '0;
      mode_d    = mode_e'(mode);
      m_valid_d = 1'b0;
    end else if (step) begin
      if (ix_q == X_LAST) begin
        ix_d = '0;
        iy_d = iy_q + 1'b1;
      end else ix_d = ix_q + 1'b1;
      if (emit) begin
        m_valid_d = 1'b1;
        m_data_d  = kpix;
        m_sof_d   = (ox_q == '0) && (oy_q == '0);
        m_eol_d   = (ox_q == X_LAST);
        if (ox_q == X_LAST) begin
          ox_d = '0;
          oy_d = oy_q + 1'b1;
        end else ox_d = ox_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ix_q <= '0;  iy_q <= '0;  ox_q <= '0;  oy_q <= '0;  mode_q <= MODE_SUM;
      m_valid_q <= 1'b0;  m_data_q <= '0;  m_sof_q <= 1'b0;  m_eol_q <= 1'b0;
    end else begin
      ix_q <= ix_d;  iy_q <= iy_d;  ox_q <= ox_d;  oy_q <= oy_d;  mode_q <= mode_d;
      m_valid_q <= m_valid_d;  m_data_q <= m_data_d;  m_sof_q <= m_sof_d;  m_eol_q <= m_eol_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_sof   = m_sof_q;
  assign m_eol   = m_eol_q;

endmodule

// File: tb/tb_stream_edge_filter.sv
// Bench for stream_edge_filter on a 4x3 image: random/directed frames against a neighbourhood model.
module tb_stream_edge_filter;

  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int N  = W * H;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] mode = 2'd0;
  logic s_valid = 1'b0, s_sof = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic s_ready, m_valid, m_sof, m_eol, busy;
  logic m_ready = 1'b1;
  logic [DW-1:0] m_data;

  int checks = 0;
  int errors = 0;
  bit stall_en = 1'b0;
  bit gap_en = 1'b0;
  int img [N];
  int got [$];
  int exp_q [$];
  logic prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  stream_edge_filter #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .mode(mode),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_sof(s_sof),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_sof(m_sof), .m_eol(m_eol),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got_v, input int exp_v);
    checks++;
    if (got_v != exp_v) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got_v, exp_v);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    m_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: handshakes seen at the falling edge complete on the next rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall) chk("hold", int'({m_valid, m_data}), int'({1'b1, prev_data}));
      if (m_valid && m_ready) got.push_back(int'({m_sof, m_eol, m_data}));
      prev_stall <= m_valid && !m_ready;
      prev_data  <= m_data;
    end else begin
      prev_stall <= 1'b0;
    end
  end

  function automatic int px(int x, int y);
    if (x < 0 || x >= W || y < 0 || y >= H) return 0;
    return img[y*W + x];
  endfunction

  function automatic int model(int m, int x, int y);
    int gx, gy, s;
    gx = (px(x+1, y-1) + 2*px(x+1, y) + px(x+1, y+1)) - (px(x-1, y-1) + 2*px(x-1, y) + px(x-1, y+1));
    gy = (px(x-1, y+1) + 2*px(x, y+1) + px(x+1, y+1)) - (px(x-1, y-1) + 2*px(x, y-1) + px(x+1, y-1));
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    case (m)
      0: s = gx + gy;
      1: s = gx;
      2: s = gy;
      default: begin
        s = 0;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++)
            s += px(x+dx, y+dy) * ((dx == 0) ? 2 : 1) * ((dy == 0) ? 2 : 1);
        return s / 16;
      end
    endcase
    return (s > 255) ? 255 : s;
  endfunction

  task automatic expect_frame(input int m);
    for (int i = 0; i < N; i++)
      exp_q.push_back(((i == 0) ? 512 : 0) + (((i % W) == W-1) ? 256 : 0) + model(m, i % W, i / W));
  endtask

  task automatic push_pix(input int d, input bit sof);
    bit done;
    done = 1'b0;
    s_valid = 1'b1;
    s_data  = DW'(d);
    s_sof   = sof;
    for (int t = 0; t < 1000 && !done; t++) begin
      @(negedge clk);
      if (s_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!done) chk("in_timeout", 0, 1);
    s_valid = 1'b0;
    s_sof   = 1'b0;
    if (gap_en && $urandom_range(0, 3) == 0) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int n, input int sw_at, input int sw_mode);
    for (int i = 0; i < n; i++) begin
      if (i == sw_at) mode = 2'(sw_mode);
      push_pix(img[i], i == 0);
    end
  endtask

  task automatic collect(input string tag);
    int n, g, e;
    n = exp_q.size();
    for (int t = 0; t < 3000 && got.size() < n; t++) @(posedge clk);
    repeat (20) @(posedge clk);
    #1;
    chk({tag, "_count"}, got.size(), n);
    chk({tag, "_idle"}, int'(busy), 0);
    while (exp_q.size() > 0 && got.size() > 0) begin
      g = got.pop_front();
      e = exp_q.pop_front();
      chk({tag, "_dat"}, g & 255, e & 255);
      chk({tag, "_flags"}, g >> 8, e >> 8);
    end
    got.delete();
    exp_q.delete();
  endtask

  task automatic rand_img();
    for (int i = 0; i < N; i++) img[i] = $urandom_range(0, 255);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks %0d", checks);
    $fatal(1);
  end

  initial begin
    int m;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", int'(s_ready), 0);
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_m_data", int'(m_data), 0);
    chk("rst_flags", int'({m_sof, m_eol}), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Pixels without start-of-frame are dropped while idle.
    push_pix(77, 1'b0);
    push_pix(33, 1'b0);
    chk("idle_drop_busy", int'(busy), 0);

    foreach (img[i]) img[i] = 100;
    mode = 2'd0;
    expect_frame(0);
    send(N, -1, 0);
    collect("const");

    foreach (img[i]) img[i] = 0;
    img[1*W + 1] = 10;
    expect_frame(0);
    send(N, -1, 0);
    collect("imp_sobel");
    mode = 2'd3;
    expect_frame(3);
    send(N, -1, 0);
    collect("imp_blur");

    stall_en = 1'b1;
    gap_en   = 1'b1;
    foreach (img[i]) img[i] = 100;
    mode = 2'd0;
    expect_frame(0);
    send(N, -1, 0);
    collect("stall");
    stall_en = 1'b0;
    gap_en   = 1'b0;

    // Abort: only the aborted frame's (0,0), already pending at the abort, gets out.
    rand_img();
    exp_q.push_back(512 + model(0, 0, 0));
    send(6, -1, 0);
    rand_img();
    expect_frame(0);
    send(N, -1, 0);
    collect("abort");

    rand_img();
    mode = 2'd0;
    expect_frame(0);
    send(N, 6, 3);
    collect("modesw_cur");
    rand_img();
    expect_frame(3);
    send(N, -1, 0);
    collect("modesw_next");

    rand_img();
    mode = 2'd1;
    send(N, -1, 0);
    chk("flush_busy", int'(busy), 1);
    chk("flush_s_ready", int'(s_ready), 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_flush_m_valid", int'(m_valid), 0);
    chk("rst_flush_busy", int'(busy), 0);
    chk("rst_flush_s_ready", int'(s_ready), 0);
    got.delete();
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("rst_flush_quiet", got.size(), 0);
    got.delete();
    rand_img();
    mode = 2'd2;
    expect_frame(2);
    send(N, -1, 0);
    collect("after_rst");

    for (int f = 0; f < 6; f++) begin
      stall_en = 1'($urandom_range(0, 1));
      gap_en   = 1'($urandom_range(0, 1));
      rand_img();
      m = $urandom_range(0, 3);
      mode = 2'(m);
      expect_frame(m);
      send(N, -1, 0);
      collect("rand");
    end
    stall_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_edge_filter.md
STREAM_EDGE_FILTER -- requirements
Module: stream_edge_filter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, pixel width in bits.
REQ-002 The block SHALL have parameter IMG_W, default 640, pixels per row (range 3..2047).
REQ-003 The block SHALL have parameter IMG_H, default 480, rows per frame (range 3..2047).
REQ-004 The block SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-005 The block SHALL have port rst, input, 1 bit, reset; synchronous, active-high.
REQ-006 The block SHALL have port mode, input, 2 bits: 0 = |Gx|+|Gy|, 1 = |Gx|, 2 = |Gy|, 3 = 1-2-1 Gaussian blur; sampled only at frame start.
REQ-007 The block SHALL have ports s_valid (in, 1), s_ready (out, 1), s_data (in, DATA_W) and s_sof (in, 1), forming a raster input stream; s_sof marks pixel (0,0).
REQ-008 The block SHALL have ports m_valid (out, 1), m_ready (in, 1), m_data (out, DATA_W), m_sof (out, 1) and m_eol (out, 1), forming the raster output stream.
REQ-009 The block SHALL have port busy, output, 1 bit, high whenever the FSM is not IDLE.

Function
REQ-010 A transfer SHALL occur on a rising clk edge when valid and ready are both high; once asserted, m_valid and m_data SHALL hold until accepted.
REQ-011 The FSM SHALL have states IDLE, FILL, RUN and FLUSH.
REQ-012 IDLE: s_ready high; pixels without s_sof SHALL be dropped; a transfer with s_sof SHALL store the pixel, latch mode and enter FILL.
REQ-013 FILL SHALL accept pixels with m_valid low until IMG_W+2 pixels have been accepted (first window complete), then enter RUN.
REQ-014 RUN: each accepted input SHALL produce exactly one output; s_ready = m_ready OR NOT m_valid.
REQ-015 After the last input pixel (IMG_W-1, IMG_H-1) is accepted, the FSM SHALL enter FLUSH with s_ready low and emit the remaining IMG_W+1 outputs using zero inputs, then return to IDLE.
REQ-016 Every frame SHALL produce exactly IMG_W*IMG_H outputs in raster order; m_sof SHALL be high on output (0,0) and m_eol on x = IMG_W-1.
REQ-017 Output (x,y) SHALL be computed from the 3x3 neighbourhood centred on input (x,y); neighbours outside the image SHALL read as 0.
REQ-018 Row storage SHALL be two line buffers of IMG_W x DATA_W plus a 3x3 window register; rows SHALL not wrap across the left and right borders.
REQ-019 Gx = (right column weighted 1,2,1) - (left column weighted 1,2,1) and Gy = (bottom row weighted 1,2,1) - (top row weighted 1,2,1), each computed signed at DATA_W+4 bits.
REQ-020 Modes 0–2 SHALL take absolute values, sum as selected, and saturate the result to 2^DATA_W-1.
REQ-021 Mode 3 SHALL compute the weighted sum (corners 1, edges 2, centre 4) shifted right by 4, truncated.
REQ-022 s_sof during FILL or RUN SHALL abort the frame: discard pending state, drop m_valid, and restart FILL with that pixel as (0,0).
REQ-023 Changes to mode mid-frame SHALL have no effect until the next frame.

Reset
REQ-024 While rst is high, on each clk edge: FSM = IDLE, counters = 0, m_valid = 0, m_sof = 0, m_eol = 0, m_data = 0, busy = 0; s_ready SHALL read 0 during reset.
REQ-025 Line-buffer contents SHALL need no reset (zero padding comes from counters, not stored data); rst mid-frame SHALL discard the frame without emitting further outputs.

Structure
REQ-026 The FSM state enum and the mode encoding SHALL live in the shared package edge_filter_pkg.
REQ-027 The 3x3 arithmetic (Sobel, saturation, blur) SHALL be a combinational sub-module kernel3x3 taking the window and mode.
REQ-028 Line buffers SHALL be inferable as single-port-per-cycle RAM (one read and one write per accepted pixel).

Verification (IMG_W=4, IMG_H=3, DATA_W=8)
REQ-029 Constant frame of 100, mode 0: output (0,0) = 255 (saturated from 600), (1,1) = 0, exactly 12 outputs, m_sof on the first and m_eol on outputs 4, 8 and 12.
REQ-030 Impulse of 10 at (1,1), otherwise 0, mode 0: (0,1) = 20, (1,1) = 0, (2,2) = 20; same frame in mode 3: (1,1) = 2.
REQ-031 m_ready toggled randomly, constant image: output identical to the no-stall run; no drops or duplicates; m_data stable while m_valid is high and m_ready is low.
REQ-032 s_sof reasserted at input pixel 6: first frame aborted with no output after the abort; second frame outputs a full 12 pixels.
REQ-033 rst asserted during FLUSH: next cycle m_valid = 0 and busy = 0; a following frame completes normally.
REQ-034 mode changed from 0 to 3 mid-frame: current frame stays Sobel, next frame is blurred.
